// File: rtl/csr_counter_unit.sv
// CSR execution block: mcycle/minstret counters, mscratch and
// CSRRW/RS/RC (register and immediate forms), old value returned.
module csr_counter_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [2:0]      csr_funct3,
  input  logic [11:0]     csr_addr,
  input  logic [4:0]      csr_rs1_idx,
  input  logic [XLEN-1:0] csr_rs1_data,
  input  logic            stall,
  input  logic            flush,
  input  logic            instr_retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal
);

  localparam int HW = CNT_W - XLEN;

  logic [CNT_W-1:0] r_mcycle;
  logic [CNT_W-1:0] r_minstret;
  logic [XLEN-1:0]  r_mscratch;

  logic            w_cyc_lo, w_cyc_hi;
  logic            w_ins_lo, w_ins_hi;
  logic            w_scr, w_known;
  logic [XLEN-1:0] w_old, w_opnd, w_new;
  logic            w_f3_bad, w_wr_req, w_ro;
  logic            w_commit;

  always_comb begin
    w_cyc_lo = 1'b0;
    w_cyc_hi = 1'b0;
    w_ins_lo = 1'b0;
    w_ins_hi = 1'b0;
    w_scr    = 1'b0;
    case (csr_addr)
      12'hC00, 12'hB00: w_cyc_lo = 1'b1;
      12'hC80, 12'hB80: w_cyc_hi = 1'b1;
      12'hC02, 12'hB02: w_ins_lo = 1'b1;
      12'hC82, 12'hB82: w_ins_hi = 1'b1;
      12'h340:          w_scr    = 1'b1;
      default: ;
    endcase
  end

  assign w_known = w_cyc_lo | w_cyc_hi | w_ins_lo
                 | w_ins_hi | w_scr;

  always_comb begin
    w_old = '0;
    unique case (1'b1)
      w_cyc_lo: w_old = r_mcycle[XLEN-1:0];
      w_cyc_hi: w_old = XLEN'(r_mcycle[CNT_W-1:XLEN]);
      w_ins_lo: w_old = r_minstret[XLEN-1:0];
      w_ins_hi: w_old = XLEN'(r_minstret[CNT_W-1:XLEN]);
      w_scr:    w_old = r_mscratch;
      default:  w_old = '0;
    endcase
  end

  assign w_opnd = csr_funct3[2] ? XLEN'(csr_rs1_idx)
                                : csr_rs1_data;

  always_comb begin
    w_new = w_old;
    case (csr_funct3[1:0])
      2'b01:   w_new = w_opnd;
      2'b10:   w_new = w_old | w_opnd;
      2'b11:   w_new = w_old & ~w_opnd;
      default: w_new = w_old;
    endcase
  end

  // Set/clear with rs1/zimm == 0 is a pure read
  assign w_f3_bad = (csr_funct3[1:0] == 2'b00);
  assign w_wr_req = (csr_funct3[1:0] == 2'b01)
                  | (!w_f3_bad && csr_rs1_idx != 5'd0);
  assign w_ro     = (csr_addr[11:10] == 2'b11);

  assign csr_illegal = csr_valid
                     & (w_f3_bad | ~w_known | (w_wr_req & w_ro));
  assign csr_rdata   = w_old;

  assign w_commit = csr_valid & ~csr_illegal & w_wr_req
                  & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
      r_mscratch <= '0;
    end else begin
      if (w_commit && w_cyc_lo)
        r_mcycle <= {r_mcycle[CNT_W-1:XLEN], w_new};
      else if (w_commit && w_cyc_hi)
        r_mcycle <= {w_new[HW-1:0], r_mcycle[XLEN-1:0]};
      else
        r_mcycle <= r_mcycle + CNT_W'(1);

      if (w_commit && w_ins_lo)
        r_minstret <= {r_minstret[CNT_W-1:XLEN], w_new};
      else if (w_commit && w_ins_hi)
        r_minstret <= {w_new[HW-1:0], r_minstret[XLEN-1:0]};
      else if (instr_retire)
        r_minstret <= r_minstret + CNT_W'(1);

      if (w_commit && w_scr)
        r_mscratch <= w_new;
    end
  end

endmodule
